dcmctrl_spi_host: RTL and testbench
===================================

DCMCTRL_SPI_HOST -- requirements
Module: dcmctrl_spi_host

Interface
REQ-001 Parameter DIV, default 8: SPI half-period in clk cycles; legal range 6..255.
REQ-002 Parameter MAXLEN_W, default 4: width of the cmd_len field.
REQ-003 clk  in  1  single system clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted on any cycle with cmd_valid && cmd_ready.
REQ-007 cmd_write  in  1  1 = write transaction, 0 = read transaction.
REQ-008 cmd_addr  in  7  start register address.
REQ-009 cmd_len  in  MAXLEN_W  data-byte count; 0 means 2^MAXLEN_W.
REQ-010 wr_data  in  8  write byte; wr_valid in 1; wr_ready out 1 (valid/ready stream).
REQ-011 rd_data  out  8  received byte; rd_valid out 1, one-cycle pulse, no backpressure.
REQ-012 busy  out  1  high from command acceptance until return to IDLE.
REQ-013 spi_ss  out  1  slave select, active low; spi_clk out 1; spi_mosi out 1; spi_miso in 1.

Function
REQ-014 The protocol is SPI mode 0, MSB first: spi_clk idles low, the peer samples MOSI on rising edges, and the peer drives MISO after falling edges.
REQ-015 Frame layout: byte 0 = {cmd_write, cmd_addr}, followed by N = cmd_len data bytes; the peer auto-increments the address per data byte, mod 128.
REQ-016 Reads: MISO during byte 0 is discarded; data byte k (k = 1..N) returns register addr+k-1.
REQ-017 Writes: MOSI data byte k goes to addr+k-1; MISO bytes are still captured and emitted on rd_data/rd_valid.
REQ-018 Read transactions drive MOSI data bytes as 0x00 and never assert wr_ready.
REQ-019 FSM states: IDLE -> SETUP -> LOW -> HIGH -> (LOW | BYTE) ; BYTE -> (LOW | HOLD) ; HOLD -> GAP -> IDLE.
REQ-020 IDLE: spi_ss=1, spi_clk=0, cmd_ready=1; on accept, latch all cmd fields and go to SETUP.
REQ-021 SETUP: spi_ss=0, MOSI = bit 7 of byte 0; stay DIV cycles.
REQ-022 HIGH: spi_clk=1; stay DIV cycles.
REQ-023 LOW: spi_clk=0; MOSI is updated on entry from HIGH; stay DIV cycles.
REQ-024 spi_miso SHALL pass through a 2-flop synchronizer.
REQ-025 The synchronized MISO is shifted in on the last cycle of each HIGH half.
REQ-026 BYTE is entered after the HIGH half of bit 0 with spi_clk=0.
REQ-027 In BYTE: if the finished byte is a data byte, present it on rd_data with rd_valid=1 for exactly one cycle.
REQ-028 In BYTE: if bytes remain and the transaction is a write, assert wr_ready and wait; on wr_valid && wr_ready, load wr_data and go to LOW.
REQ-029 Stall: spi_clk is held low indefinitely while wr_valid=0; stalling has no protocol effect.
REQ-030 In BYTE: if bytes remain and the transaction is a read, load 0x00 and go to LOW.
REQ-031 In BYTE: if no bytes remain, go to HOLD.
REQ-032 The first write byte SHALL be requested in BYTE after byte 0, so a write of N bytes asserts wr_ready exactly N times.
REQ-033 The low time at a byte boundary SHALL be >= DIV cycles, so the peer's byte-reload latency (<= 5 clk) is met.
REQ-034 HOLD: spi_ss=0, spi_clk=0 for DIV cycles. GAP: spi_ss=1 for DIV cycles; cmd_ready stays 0 throughout.
REQ-035 Unstalled ss-low time = DIV*(2 + 16*(N+1)) + (N+1) clk cycles, the +1 per byte being the BYTE cycle.
REQ-036 The bit counter is 3 bits and the byte counter is MAXLEN_W+1 bits; no other arithmetic wraps.
REQ-037 spi_ss, spi_clk and spi_mosi SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-038 During and after reset: spi_ss=1, spi_clk=0, spi_mosi=0, rd_valid=0, rd_data=0x00, wr_ready=0, busy=0, cmd_ready=1, FSM=IDLE.
REQ-039 Reset mid-transaction SHALL abort without completing the byte; the peer discards its partial state on ss high, so no write is committed for the incomplete byte.
REQ-040 The next command after reset SHALL start a fresh frame at byte 0.

Verification
REQ-041 Write, addr 0x05, len 3, data A1 B2 C3, then read addr 0x05, len 3 -> rd_data A1, B2, C3; spi_ss-low length matches REQ-035 with N=3.
REQ-042 Read addr 0x7F, len 2, peer regs 0x7F=0x11 and 0x00=0x22 -> rd_data 0x11 then 0x22 (address wrap).
REQ-043 Write len 2 with wr_valid withheld 50 cycles before the second byte -> spi_clk stays low 50+ cycles; memory ends with both bytes correct.
REQ-044 reset asserted at the 4th rising spi_clk of data byte 1 -> same cycle spi_ss=1, spi_clk=0; target register unchanged; the following command completes normally.
REQ-045 cmd_len=0 read -> exactly 16 rd_valid pulses; back-to-back commands keep spi_ss high >= DIV cycles between frames.
REQ-046 DIV=6 against the motor controller's SPI register port -> every bit is sampled correctly and there are no reload-timing errors over 1000 random transactions.

Source files
------------

// File: rtl/dcmctrl_spi_host.sv
// dcmctrl_spi_host: SPI mode-0 register-port host with a {rw,addr} header byte and N auto-incrementing data bytes.
module dcmctrl_spi_host #(
  parameter int DIV      = 8,
  parameter int MAXLEN_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [6:0]          cmd_addr,
  input  logic [MAXLEN_W-1:0] cmd_len,
  input  logic [7:0]          wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                spi_ss,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso
);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, BYTE, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, sh_q, sh_d, rd_data_q, rd_data_d;
  logic [2:0] bit_q, bit_d;
  logic [MAXLEN_W:0] rem_q, rem_d;
  logic wr_q, wr_d, first_q, first_d, rd_valid_q, rd_valid_d;
  logic ss_q, ss_d, clk_q, clk_d, mosi_q, mosi_d, miso_s1_q, miso_s2_q;
  logic last, more;
  logic [7:0] sh_in;
  assign last = cnt_q == 8'(DIV - 1);
  assign more = rem_q != '0;
  assign sh_in = {sh_q[6:0], miso_s2_q};
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign wr_ready = state_q == BYTE && wr_q && more;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign spi_ss = ss_q;
  assign spi_clk = clk_q;
  assign spi_mosi = mosi_q;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    rem_d = rem_q;
    wr_d = wr_q;
    first_d = first_q;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    ss_d = ss_q;
    clk_d = clk_q;
    mosi_d = mosi_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;
        wr_d = cmd_write;
        rem_d = cmd_len == '0 ? {1'b1, {MAXLEN_W{1'b0}}} : {1'b0, cmd_len};
        sh_d = {cmd_write, cmd_addr};
        first_d = 1'b1;
        bit_d = 3'd7;
        ss_d = 1'b0;
        mosi_d = cmd_write;
      end
      SETUP: state_d = last ? LOW : SETUP;
      LOW: if (last) begin
        state_d = HIGH;
        clk_d = 1'b1;
      end
      // Sample on the last HIGH cycle; the falling edge and next MOSI bit land together.
      HIGH: if (last) begin
        sh_d = sh_in;
        clk_d = 1'b0;
        bit_d = bit_q - 3'd1;
        state_d = bit_q == 3'd0 ? BYTE : LOW;
        rd_valid_d = bit_q == 3'd0 && !first_q;
        rd_data_d = bit_q == 3'd0 ? sh_in : rd_data_q;
        mosi_d = bit_q == 3'd0 ? mosi_q : sh_in[7];
      end
      BYTE: if (!more) state_d = HOLD;
      else if (!wr_q || wr_valid) begin
        state_d = LOW;
        sh_d = wr_q ? wr_data : 8'h00;
        mosi_d = wr_q && wr_data[7];
        rem_d = rem_q - 1'b1;
        first_d = 1'b0;
      end
      HOLD: if (last) begin
        state_d = GAP;
        ss_d = 1'b1;
      end
      GAP: state_d = last ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  assign cnt_d = (state_d != state_q || state_q == IDLE || state_q == BYTE) ? 8'd0 : cnt_q + 8'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
      rem_q <= '0;
      wr_q <= 1'b0;
      first_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      ss_q <= 1'b1;
      clk_q <= 1'b0;
      mosi_q <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      rem_q <= rem_d;
      wr_q <= wr_d;
      first_q <= first_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_q <= ss_d;
      clk_q <= clk_d;
      mosi_q <= mosi_d;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end
endmodule

// File: tb/tb_dcmctrl_spi_host.sv
// tb_dcmctrl_spi_host: SPI register-peer model plus a transaction-level reference memory checking the host.
module tb_dcmctrl_spi_host;
  localparam int DIV = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wr_data = '0, rd_data;
  logic wr_valid = 1'b0, wr_ready, rd_valid, busy;
  logic spi_ss, spi_clk, spi_mosi, spi_miso = 1'b0;
  dcmctrl_spi_host #(.DIV(DIV), .MAXLEN_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .spi_ss(spi_ss), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic expired(input string nm, input int t, input int lim);
    if (t >= lim) begin
      checks++;
      errors++;
      $display("FAIL %s: waited %0d cycles, limit %0d", nm, t, lim);
    end
  endtask
  // Peer register port: samples MOSI on rising edges, shifts MISO after falling edges.
  logic [7:0] mem [128];
  logic p_clk = 1'b0, p_w = 1'b0, p_reload = 1'b0;
  logic [6:0] p_addr = '0;
  logic [7:0] p_rx = '0, p_tx = '0;
  int p_cnt = 0, p_byte = 0;
  always @(negedge clk) begin
    if (spi_ss) begin
      p_cnt = 0; p_byte = 0; p_reload = 1'b0; p_tx = '0; spi_miso = 1'b0;
    end else begin
      if (spi_clk && !p_clk) begin
        p_rx = {p_rx[6:0], spi_mosi};
        p_cnt++;
        if (p_cnt == 8) begin
          p_cnt = 0;
          if (p_byte == 0) begin
            p_w = p_rx[7]; p_addr = p_rx[6:0];
          end else begin
            if (p_w) mem[p_addr] = p_rx;
            p_addr = p_addr + 7'd1;
          end
          p_byte++;
          p_tx = mem[p_addr];
          p_reload = 1'b1;
        end
      end
      if (!spi_clk && p_clk) begin
        if (p_reload) p_reload = 1'b0;
        else p_tx = {p_tx[6:0], 1'b0};
        spi_miso = p_tx[7];
      end
    end
    p_clk = spi_clk;
  end
  logic [7:0] ref_mem [128];
  logic [7:0] wbuf [16];
  logic [7:0] exp_q[$], got_q[$];
  logic cur_w = 1'b0, m_clk = 1'b0;
  int ss_lo = 0, last_lo = 0, ss_hi = 0, last_gap = 0, clk_lo = 0, max_clk_lo = 0, rises = 0, hs = 0;
  always @(negedge clk) begin
    if (rd_valid) begin
      got_q.push_back(rd_data);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_extra: got %0h expected no byte", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end
    if (!reset) begin
      chk("ready_vs_busy", cmd_ready, !busy);
      if (!cur_w) chk("wr_ready_on_read", wr_ready, 1'b0);
      if (!busy) chk("ss_idle", spi_ss, 1'b1);
    end
    if (wr_valid && wr_ready) hs++;
    if (!spi_ss) begin
      if (ss_lo == 0) last_gap = ss_hi;
      ss_lo++; ss_hi = 0;
    end else begin
      if (ss_lo > 0) last_lo = ss_lo;
      ss_lo = 0; ss_hi++;
    end
    if (spi_ss) rises = 0;
    else if (spi_clk && !m_clk) rises++;
    if (!spi_ss && !spi_clk) begin
      clk_lo++;
      if (clk_lo > max_clk_lo) max_clk_lo = clk_lo;
    end else clk_lo = 0;
    m_clk = spi_clk;
  end
  task automatic run(input logic w, input logic [6:0] a, input logic [3:0] l,
                     input int stall_idx, input int stall_cyc, input logic chk_len);
    int n, t;
    logic [6:0] ad;
    n = (l == 4'd0) ? 16 : int'(l);
    got_q.delete(); exp_q.delete(); hs = 0; max_clk_lo = 0;
    for (int k = 0; k < n; k++) begin
      ad = a + 7'(k);
      exp_q.push_back(ref_mem[ad]);
      if (w) ref_mem[ad] = wbuf[k];
    end
    @(negedge clk);
    cur_w = w; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    expired("cmd_ready_wait", t, 1000);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (w) for (int k = 0; k < n; k++) begin
      t = 0;
      while (!wr_ready && t < 5000) begin @(negedge clk); t++; end
      expired("wr_ready_wait", t, 5000);
      if (k == stall_idx) repeat (stall_cyc) @(negedge clk);
      wr_data = wbuf[k]; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
    end
    t = 0;
    while (busy && t < 20000) begin @(negedge clk); t++; end
    expired("busy_wait", t, 20000);
    chk("rd_count", got_q.size(), n);
    chk("wr_handshakes", hs, w ? n : 0);
    if (chk_len) chk("ss_low_len", last_lo, DIV * (2 + 16 * (n + 1)) + n + 1);
  endtask
  initial begin
    int t;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'(i) ^ 8'h5C;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_ss", spi_ss, 1'b1); chk("rst_clk", spi_clk, 1'b0); chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0); chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_wr_ready", wr_ready, 1'b0); chk("rst_busy", busy, 1'b0); chk("rst_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3;
    run(1'b1, 7'h05, 4'd3, -1, 0, 1'b1);
    chk("w_mem5", mem[5], 8'hA1); chk("w_mem6", mem[6], 8'hB2); chk("w_mem7", mem[7], 8'hC3);
    run(1'b0, 7'h05, 4'd3, -1, 0, 1'b1);
    chk("r_byte0", got_q[0], 8'hA1); chk("r_byte1", got_q[1], 8'hB2); chk("r_byte2", got_q[2], 8'hC3);
    chk("ss_len_n3", last_lo, 532);
    mem[127] = 8'h11; ref_mem[127] = 8'h11; mem[0] = 8'h22; ref_mem[0] = 8'h22;
    run(1'b0, 7'h7F, 4'd2, -1, 0, 1'b1);
    chk("wrap_byte0", got_q[0], 8'h11); chk("wrap_byte1", got_q[1], 8'h22);
    wbuf[0] = 8'h5E; wbuf[1] = 8'h6F;
    run(1'b1, 7'h20, 4'd2, 1, 50, 1'b0);
    chk("stall_clk_low", max_clk_lo >= 50 + DIV, 1'b1);
    chk("stall_mem20", mem[8'h20], 8'h5E); chk("stall_mem21", mem[8'h21], 8'h6F);
    @(negedge clk);
    cur_w = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h30; cmd_len = 4'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; wr_data = 8'hE7; wr_valid = 1'b1;
    t = 0;
    while (rises < 12 && t < 5000) begin @(negedge clk); t++; end
    expired("rise_wait", t, 5000);
    reset = 1'b1;
    #1;
    chk("abort_ss", spi_ss, 1'b1); chk("abort_clk", spi_clk, 1'b0); chk("abort_busy", busy, 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_mem30", mem[8'h30], 8'h6C);
    run(1'b0, 7'h30, 4'd1, -1, 0, 1'b1);
    chk("after_abort_rd", got_q[0], 8'h6C);
    run(1'b0, 7'h40, 4'd0, -1, 0, 1'b1);
    wbuf[0] = 8'h77;
    run(1'b1, 7'h50, 4'd1, -1, 0, 1'b1);
    chk("ss_gap", last_gap >= DIV, 1'b1);
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
      run(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom_range(1, 4)), -1, 0, 1'b1);
    end
    for (int i = 0; i < 128; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
